cu_fsm_hs: RTL and testbench

Parametrised multicycle control FSM for the OTTER RV32I core that sequences fetch, execute, writeback and trap entry. Unlike a fixed-latency controller, it waits on a memory ready handshake, bounds every memory wait with a timeout counter, decodes SYSTEM/CSR instructions and diverts to a trap state for interrupts, illegal opcodes and bus timeouts. It drives PC, register-file, memory and CSR enables and sits between the instruction register and the datapath.

---
 rtl/cu_pkg.sv | 34 +++
 rtl/cu_wait_timer.sv | 34 +++
 rtl/cu_fsm_hs.sv | 180 ++++++++++++++++++
 tb/tb_cu_fsm_hs.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// RV32I major opcodes and the trap-cause codes reported on trap_cause.
package cu_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        TRAP  = 3'd4
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_INTR    = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_BUS     = 2'b11;

    // Counter width able to hold 0..limit; a disabled timer still needs one bit.
    function automatic int timer_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Memory-wait counter. Counts enabled cycles since the last clear and flags
// the cycle on which the LIMIT-th consecutive wait is happening.
module cu_wait_timer
    import cu_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = timer_width(LIMIT);
    localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;
    localparam bit ENABLED = (LIMIT > 0);

    logic [W-1:0] count_reg;

    // Clear on reset or state change, otherwise count wait cycles (saturating).
    always_ff @(posedge clk) begin
        if (RST || clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // The current wait cycle is the last one allowed when the count has
    // already reached LIMIT-1 earlier waits.
    assign expired = ENABLED && (count_reg == LAST);

endmodule

// File: rtl/cu_fsm_hs.sv
// Multicycle OTTER control FSM with memory-ready handshake, per-access wait
// timeout and trap entry for interrupts, illegal opcodes and bus timeouts.
module cu_fsm_hs
    import cu_pkg::*;
#(
    parameter int MEM_HS  = 1,
    parameter int TIMEOUT = 16,
    parameter int INTR_EN = 1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       intr,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_we2,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       reset,
    output logic       csr_we,
    output logic       mret_exec,
    output logic       trap_taken,
    output logic [1:0] trap_cause
);

    state_t     ps_reg;
    state_t     ns_next;
    logic [1:0] trap_cause_reg;
    logic [1:0] cause_next;
    logic       ready;
    logic       waiting;
    logic       complete;
    logic       expired;
    logic       timer_clr;

    // Zero-wait builds see every access finish immediately.
    assign ready     = (MEM_HS != 0) ? mem_ready : 1'b1;
    assign timer_clr = (ns_next != ps_reg);

    cu_wait_timer #(
        .LIMIT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .RST    (RST),
        .clr    (timer_clr),
        .en     (waiting),
        .expired(expired)
    );

    // Next-state decode and all Moore/Mealy enables from the present state.
    always_comb begin
        ns_next    = ps_reg;
        cause_next = trap_cause_reg;
        complete   = 1'b0;
        waiting    = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_we2    = 1'b0;
        mem_rden1  = 1'b0;
        mem_rden2  = 1'b0;
        reset      = 1'b0;
        csr_we     = 1'b0;
        mret_exec  = 1'b0;
        trap_taken = 1'b0;

        case (ps_reg)
            INIT: begin
                reset   = 1'b1;
                ns_next = FETCH;
            end
            FETCH: begin
                mem_rden1 = 1'b1;
                if (ready) begin
                    ns_next = EXEC;
                end else begin
                    waiting = 1'b1;
                    if (expired) begin
                        ns_next    = TRAP;
                        cause_next = CAUSE_BUS;
                    end
                end
            end
            EXEC: begin
                case (opcode)
                    OP_R, OP_I, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        complete  = 1'b1;
                    end
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        complete = 1'b1;
                    end
                    OP_LOAD: begin
                        mem_rden2 = 1'b1;
                        ns_next   = WB;
                    end
                    OP_STORE: begin
                        if (ready) begin
                            mem_we2  = 1'b1;
                            pc_write = 1'b1;
                            complete = 1'b1;
                        end else begin
                            waiting = 1'b1;
                            // The write strobe is withdrawn on the aborting cycle.
                            if (expired) begin
                                ns_next    = TRAP;
                                cause_next = CAUSE_BUS;
                            end else begin
                                mem_we2 = 1'b1;
                            end
                        end
                    end
                    OP_SYSTEM: begin
                        pc_write = 1'b1;
                        complete = 1'b1;
                        if (funct3 != 3'b000) begin
                            reg_write = 1'b1;
                            csr_we    = 1'b1;
                        end else begin
                            mret_exec = 1'b1;
                        end
                    end
                    default: begin
                        ns_next    = TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            WB: begin
                mem_rden2 = 1'b1;
                if (ready) begin
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    complete  = 1'b1;
                end else begin
                    waiting = 1'b1;
                    if (expired) begin
                        ns_next    = TRAP;
                        cause_next = CAUSE_BUS;
                    end
                end
            end
            TRAP: begin
                trap_taken = 1'b1;
                pc_write   = 1'b1;
                ns_next    = FETCH;
            end
            default: begin
                ns_next = INIT;
            end
        endcase

        // Interrupts are only accepted on an instruction boundary.
        if (complete) begin
            if (intr && (INTR_EN != 0)) begin
                ns_next    = TRAP;
                cause_next = CAUSE_INTR;
            end else begin
                ns_next = FETCH;
            end
        end
    end

    // State and trap-cause registers; cause changes only on trap entry.
    always_ff @(posedge clk) begin
        if (RST) begin
            ps_reg         <= INIT;
            trap_cause_reg <= CAUSE_NONE;
        end else begin
            ps_reg         <= ns_next;
            trap_cause_reg <= cause_next;
        end
    end

    assign trap_cause = trap_cause_reg;

endmodule

// File: tb/tb_cu_fsm_hs.sv
// Self-checking bench for cu_fsm_hs. Three builds share the stimulus; the one
// selected by sel is compared against a per-instruction trace model.
module tb_cu_fsm_hs;

    logic       clk = 1'b0;
    logic       RST;
    logic       intr;
    logic       mem_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;

    always #5 clk = ~clk;

    // Output bit order: pc_write reg_write mem_we2 mem_rden1 mem_rden2 reset csr_we mret_exec trap_taken
    localparam logic [8:0] E_PC   = 9'h100;
    localparam logic [8:0] E_RW   = 9'h080;
    localparam logic [8:0] E_WE   = 9'h040;
    localparam logic [8:0] E_RD1  = 9'h020;
    localparam logic [8:0] E_RD2  = 9'h010;
    localparam logic [8:0] E_RST  = 9'h008;
    localparam logic [8:0] E_CSR  = 9'h004;
    localparam logic [8:0] E_MRET = 9'h002;
    localparam logic [8:0] E_TRAP = 9'h001;

    localparam int C_ALU = 0, C_BR = 1, C_LD = 2, C_ST = 3, C_CSR = 4, C_MRET = 5, C_ILL = 6;

    localparam int P_HS [3] = '{1, 1, 0};
    localparam int P_TO [3] = '{4, 4, 0};
    localparam int P_IE [3] = '{1, 0, 1};

    wire [2:0][8:0] ov;
    wire [2:0][1:0] cv;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            cu_fsm_hs #(
                .MEM_HS (P_HS[gi]),
                .TIMEOUT(P_TO[gi]),
                .INTR_EN(P_IE[gi])
            ) dut (
                .clk       (clk),
                .RST       (RST),
                .opcode    (opcode),
                .funct3    (funct3),
                .intr      (intr),
                .mem_ready (mem_ready),
                .pc_write  (ov[gi][8]),
                .reg_write (ov[gi][7]),
                .mem_we2   (ov[gi][6]),
                .mem_rden1 (ov[gi][5]),
                .mem_rden2 (ov[gi][4]),
                .reset     (ov[gi][3]),
                .csr_we    (ov[gi][2]),
                .mret_exec (ov[gi][1]),
                .trap_taken(ov[gi][0]),
                .trap_cause(cv[gi])
            );
        end
    endgenerate

    logic [1:0]  sel;
    logic [10:0] obs;
    always_comb obs = {ov[sel], cv[sel]};

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        irq;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [10:0] exp;
        bit          chk;
        string       name;
    } cyc_t;

    cyc_t sched[$];
    cyc_t c;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state for the configuration under test.
    bit         hs;
    int         to;
    bit         ie;
    logic [1:0] m_cause;
    logic       m_rst;
    int         m_n;
    int         m_from;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;

    function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0110011, 7'b0010011, 7'b1100111,
            7'b1101111, 7'b0110111, 7'b0010111: return C_ALU;
            7'b1100011: return C_BR;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1110011: return (f3 != 3'b000) ? C_CSR : C_MRET;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic [8:0] v, input string nm);
        cyc_t r;
        r.rst  = m_rst;
        r.rdy  = rdy;
        r.irq  = (m_n >= m_from);
        r.op   = cur_op;
        r.f3   = cur_f3;
        r.exp  = {v, m_cause};
        r.chk  = 1'b1;
        r.name = nm;
        sched.push_back(r);
        m_n++;
    endtask

    // An instruction-ending cycle: the interrupt level on it decides a trap.
    task automatic finish(input logic rdy, input logic [8:0] v, input string nm,
                          inout logic [1:0] trap);
        push(rdy, v, nm);
        if (sched[$].irq && ie) trap = 2'b01;
    endtask

    // Expected cycle trace of one instruction from FETCH back to FETCH.
    task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3,
                              input int wf_in, input int ww_in, input int irq_from);
        int         wf;
        int         ww;
        int         cls;
        logic [1:0] trap;
        bit         fin;
        wf = hs ? wf_in : 0;
        ww = hs ? ww_in : 0;
        cur_op = op;
        cur_f3 = f3;
        m_n    = 0;
        m_from = irq_from;
        trap   = 2'b00;
        cls    = classify(op, f3);
        fin    = 1'b0;
        for (int k = 0; !fin; k++) begin
            if (k == wf) begin
                push(hs, E_RD1, "fetch"); fin = 1'b1;
            end else if (to > 0 && k == to - 1) begin
                push(1'b0, E_RD1, "fetch_timeout"); trap = 2'b11; fin = 1'b1;
            end else begin
                push(1'b0, E_RD1, "fetch_wait");
            end
        end
        if (trap == 2'b00) begin
            case (cls)
                C_ALU:  finish(rnd(), E_PC | E_RW, "exec_alu", trap);
                C_BR:   finish(rnd(), E_PC, "exec_branch", trap);
                C_CSR:  finish(rnd(), E_PC | E_RW | E_CSR, "exec_csr", trap);
                C_MRET: finish(rnd(), E_PC | E_MRET, "exec_mret", trap);
                C_LD: begin
                    push(rnd(), E_RD2, "load_exec");
                    fin = 1'b0;
                    for (int k = 0; !fin; k++) begin
                        if (k == ww) begin
                            finish(hs, E_RD2 | E_PC | E_RW, "wb_done", trap); fin = 1'b1;
                        end else if (to > 0 && k == to - 1) begin
                            push(1'b0, E_RD2, "wb_timeout"); trap = 2'b11; fin = 1'b1;
                        end else begin
                            push(1'b0, E_RD2, "wb_wait");
                        end
                    end
                end
                C_ST: begin
                    fin = 1'b0;
                    for (int k = 0; !fin; k++) begin
                        if (k == ww) begin
                            finish(hs, E_WE | E_PC, "store_done", trap); fin = 1'b1;
                        end else if (to > 0 && k == to - 1) begin
                            push(1'b0, 9'h000, "store_timeout"); trap = 2'b11; fin = 1'b1;
                        end else begin
                            push(1'b0, E_WE, "store_wait");
                        end
                    end
                end
                default: begin
                    push(rnd(), 9'h000, "exec_illegal"); trap = 2'b10;
                end
            endcase
        end
        if (trap != 2'b00) begin
            m_cause = trap;
            push(rnd(), E_TRAP | E_PC, "trap");
        end
    endtask

    // RST held for ncyc edges, then the single INIT cycle.
    task automatic plan_reset(input int ncyc);
        cur_op = 7'b0110011;
        cur_f3 = 3'b000;
        m_n    = 0;
        m_from = 1000;
        m_rst  = 1'b1;
        push(rnd(), E_RST, "rst_first");
        sched[$].chk = 1'b0;
        m_cause = 2'b00;
        for (int i = 1; i < ncyc; i++) push(rnd(), E_RST, "rst_hold");
        m_rst = 1'b0;
        push(rnd(), E_RST, "init");
    endtask

    task automatic set_cfg(input int s);
        sel = 2'(s);
        hs  = (P_HS[s] != 0);
        to  = P_TO[s];
        ie  = (P_IE[s] != 0);
        plan_reset(3);
    endtask

    task automatic drive(input cyc_t r);
        RST       = r.rst;
        mem_ready = r.rdy;
        intr      = r.irq;
        opcode    = r.op;
        funct3    = r.f3;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] rand_illegal();
        logic [6:0] op;
        op = 7'($urandom_range(0, 127));
        while (classify(op, 3'b001) != C_ILL) op = 7'($urandom_range(0, 127));
        return op;
    endfunction

    task automatic test_reset();
        set_cfg(0);
        plan_instr(7'b0110011, 3'b000, 0, 0, 1000);
        while (sched.size() > 0) begin
            c = sched.pop_front(); drive(c);
            if (c.chk) begin
                n_cmp++;
                if (obs !== c.exp) begin n_bad++; $display("FAIL reset/%s: got %b want %b sel=%0d", c.name, obs, c.exp, sel); end
            end
            tick();
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0] ops [7];
        ops = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1100011};
        set_cfg(0);
        foreach (ops[i]) plan_instr(ops[i], 3'($urandom_range(0, 7)), 0, 0, 1000);
        while (sched.size() > 0) begin
            c = sched.pop_front(); drive(c);
            if (c.chk) begin
                n_cmp++;
                if (obs !== c.exp) begin n_bad++; $display("FAIL alu/%s: got %b want %b op=%b", c.name, obs, c.exp, c.op); end
            end
            tick();
        end
    endtask

    task automatic test_load_wait();
        set_cfg(0);
        plan_instr(7'b0000011, 3'b010, 0, 2, 1000);
        plan_instr(7'b0000011, 3'b010, 1, 3, 1000);
        plan_instr(7'b0100011, 3'b010, 2, 1, 1000);
        while (sched.size() > 0) begin
            c = sched.pop_front(); drive(c);
            if (c.chk) begin
                n_cmp++;
                if (obs !== c.exp) begin n_bad++; $display("FAIL load_wait/%s: got %b want %b", c.name, obs, c.exp); end
            end
            tick();
        end
    endtask

    task automatic test_timeouts();
        set_cfg(0);
        plan_instr(7'b0100011, 3'b010, 0, 100, 1000);
        plan_instr(7'b0110011, 3'b000, 0, 0, 1000);
        plan_instr(7'b0110011, 3'b000, 9, 0, 1000);
        plan_instr(7'b0000011, 3'b000, 0, 9, 1000);
        plan_instr(7'b0010011, 3'b000, 0, 0, 1000);
        while (sched.size() > 0) begin
            c = sched.pop_front(); drive(c);
            if (c.chk) begin
                n_cmp++;
                if (obs !== c.exp) begin n_bad++; $display("FAIL timeout/%s: got %b want %b", c.name, obs, c.exp); end
            end
            tick();
        end
    endtask

    task automatic test_illegal_intr();
        set_cfg(0);
        plan_instr(7'b1111111, 3'b000, 0, 0, 1000);
        plan_instr(7'b1111111, 3'b000, 0, 0, 0);
        plan_instr(7'b0110011, 3'b000, 0, 0, 0);
        plan_instr(7'b0110011, 3'b000, 0, 0, 1000);
        while (sched.size() > 0) begin
            c = sched.pop_front(); drive(c);
            if (c.chk) begin
                n_cmp++;
                if (obs !== c.exp) begin n_bad++; $display("FAIL illegal_intr/%s: got %b want %b", c.name, obs, c.exp); end
            end
            tick();
        end
    endtask

    task automatic test_intr_mid_wb();
        for (int s = 0; s < 2; s++) begin
            set_cfg(s);
            plan_instr(7'b0000011, 3'b010, 0, 3, 3);
            plan_instr(7'b0110011, 3'b000, 0, 0, 1000);
            while (sched.size() > 0) begin
                c = sched.pop_front(); drive(c);
                if (c.chk) begin
                    n_cmp++;
                    if (obs !== c.exp) begin n_bad++; $display("FAIL intr_wb/%s: got %b want %b sel=%0d", c.name, obs, c.exp, sel); end
                end
                tick();
            end
        end
    endtask

    task automatic test_system();
        set_cfg(0);
        plan_instr(7'b1110011, 3'b001, 0, 0, 1000);
        plan_instr(7'b1110011, 3'b000, 0, 0, 1000);
        plan_instr(7'b1110011, 3'($urandom_range(1, 7)), 1, 0, 1000);
        plan_instr(7'b1110011, 3'b000, 0, 0, 0);
        while (sched.size() > 0) begin
            c = sched.pop_front(); drive(c);
            if (c.chk) begin
                n_cmp++;
                if (obs !== c.exp) begin n_bad++; $display("FAIL system/%s: got %b want %b f3=%b", c.name, obs, c.exp, c.f3); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        set_cfg(0);
        plan_instr(7'b1111111, 3'b000, 0, 0, 1000);
        cur_op = 7'b0110011;
        m_n    = 0;
        m_from = 1000;
        push(1'b0, E_RD1, "fetch_wait");
        push(1'b0, E_RD1, "fetch_wait");
        m_rst = 1'b1;
        push(1'b0, E_RD1, "fetch_wait_rst");
        m_rst   = 1'b0;
        m_cause = 2'b00;
        push(rnd(), E_RST, "init_after_rst");
        plan_instr(7'b0110011, 3'b000, 3, 0, 1000);
        while (sched.size() > 0) begin
            c = sched.pop_front(); drive(c);
            if (c.chk) begin
                n_cmp++;
                if (obs !== c.exp) begin n_bad++; $display("FAIL rst_mid_wait/%s: got %b want %b", c.name, obs, c.exp); end
            end
            tick();
        end
    endtask

    task automatic test_random_back_to_back();
        int         pick;
        logic [6:0] op;
        logic [6:0] ops [10];
        ops = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b1101111, 7'b0110111,
                7'b0010111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1110011};
        for (int s = 0; s < 3; s++) begin
            set_cfg(s);
            for (int i = 0; i < 60; i++) begin
                pick = $urandom_range(0, 10);
                op   = (pick == 10) ? rand_illegal() : ops[pick];
                plan_instr(op, 3'($urandom_range(0, 7)), $urandom_range(0, 5), $urandom_range(0, 5),
                           ($urandom_range(0, 9) < 3) ? $urandom_range(0, 8) : 1000);
            end
            while (sched.size() > 0) begin
                c = sched.pop_front(); drive(c);
                if (c.chk) begin
                    n_cmp++;
                    if (obs !== c.exp) begin n_bad++; $display("FAIL random/%s: got %b want %b sel=%0d op=%b", c.name, obs, c.exp, sel, c.op); end
                end
                tick();
            end
        end
    endtask

    initial begin
        sel       = 2'd0;
        RST       = 1'b1;
        intr      = 1'b0;
        mem_ready = 1'b0;
        opcode    = 7'b0;
        funct3    = 3'b0;
        m_cause   = 2'b00;
        m_rst     = 1'b0;
        test_reset();
        test_alu_ops();
        test_load_wait();
        test_timeouts();
        test_illegal_intr();
        test_intr_mid_wb();
        test_system();
        test_reset_mid_wait();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
